pbuf_load_sched: RTL and testbench
==================================

# pbuf_load_sched

Sequencer for the parameter-buffer load path. It accepts one layer-level load command and splits it into `tile_num+1` tiles. For each tile it:
- issues one read request on each of the two DDR read channels,
- starts the `ddr2pbuf` datapath with the latched configuration,
- waits for its completion.

It sits between the layer controller and `ddr2pbuf`/DDR read engines. It owns all `conf_*`/`start` inputs of the datapath.

## Interface
Parameters:
- `PE_NUM`, 32, width of the PE write mask
- `DDR_ADDR_W`, 32, DDR byte-address width
- `LEN_W`, 11, DDR request length width (beats)

Ports:
- `clk`  in  1  clock; all logic single-clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_mode` in 4, `cmd_trans_num` in 8, `cmd_ch_num` in 4, `cmd_pix_num` in 4, `cmd_row_num` in 2, `cmd_depool` in 1, `cmd_mask` in PE_NUM: per-tile datapath config
- `cmd_tile_num`  in  8  number of tiles minus one
- `cmd_ddr1_base`, `cmd_ddr2_base`  in  DDR_ADDR_W  first-tile addresses
- `cmd_ddr1_stride`, `cmd_ddr2_stride`  in  DDR_ADDR_W  per-tile address increment
- `rd1_req_valid` out 1, `rd1_req_ready` in 1, `rd1_req_addr` out DDR_ADDR_W, `rd1_req_len` out LEN_W: channel 1 read request
- `rd2_req_*`: same set for channel 2
- `pb_start` out 1: one-cycle start pulse to datapath
- `pb_done`  in  1  datapath completion level
- `pb_conf_mode` out 4, `pb_conf_trans_num` out 8, `pb_conf_ch_num` out 4, `pb_conf_pix_num` out 4, `pb_conf_row_num` out 2, `pb_conf_depool` out 1, `pb_conf_mask` out PE_NUM
- `busy` out 1: high outside IDLE
- `sched_done` out 1: one-cycle pulse after the last tile completes

## Operation
- States:
  - IDLE → REQ on `cmd_valid && cmd_ready`; all `cmd_*` latched.
  - REQ → START once both channels accepted.
  - START → WAIT.
  - WAIT → NEXT on qualified `pb_done`.
  - NEXT → REQ if `tile_cnt != tile_num`, else → FIN.
  - FIN → IDLE.
- `cmd_ready` = 1 only in IDLE. `cmd_valid` outside IDLE is ignored.
- Update mode is `mode[2:1]==2'b10`.
- Request length, same for both channels:
  - update mode: `(ch_num+1)*(pix_num+1)*(row_num+1)`, max 1024, fits LEN_W.
  - otherwise: `trans_num+1`.
- REQ entry asserts both `rdX_req_valid`. Each drops the cycle after its own `valid&&ready`. Either order is allowed, including simultaneous acceptance. `addr`/`len` stay stable while valid.
- START: `pb_start`=1 for exactly one cycle. `pb_conf_*` are driven from latched registers and stay constant from command latch until FIN.
- WAIT: `pb_done` is ignored during the START cycle and the first WAIT cycle, because the datapath's stale done level is masked. After that, the first high sample ends the tile.
- NEXT: `tile_cnt+=1`; `addrX += strideX`, modulo 2^DDR_ADDR_W (wrap, no error).
- `tile_num=0` gives exactly one tile. `tile_num=255` gives 256 tiles; `tile_cnt` is 8 bits and never wraps before the compare.
- `rst` in any state: state → IDLE next edge; all valids, `pb_start`, `sched_done` and `busy` go to 0. Outstanding DDR requests are abandoned.

## Timing
- Reset values:
  - `cmd_ready`=1; `busy`=0; `sched_done`=0; `pb_start`=0.
  - `rd1_req_valid`=`rd2_req_valid`=0; `rd*_req_addr`/`len`=0.
  - All `pb_conf_*`=0, `pb_conf_mask`=0.
- Command accept at edge N: `rd*_req_valid` high from cycle N+1.
- Both accepted at edge M: `pb_start` high in cycle M+1.
- Qualified `pb_done` at edge K:
  - next tile's `rd*_req_valid` high in K+2 (via NEXT);
  - or, for the last tile, `sched_done` high in K+2 and `cmd_ready` high in K+3.
- Minimum per-tile overhead: 5 cycles plus DDR accept latency plus datapath time.
- All outputs registered.

## Configuration
- `PBUF_SCHED_PERF_EN` defined:
  - adds output `perf_cycles` (32 bits) = number of cycles with `busy`=1 for the last completed command;
  - cleared on command accept, saturates at 2^32-1, updated on FIN;
  - adds output `perf_stall` (32 bits) = cycles spent in REQ with any valid unaccepted.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

## Structure
- Shared package `GLOBAL_PARAM` gets:
  - state enum `pbuf_sched_state_t`;
  - function `pbuf_req_len(mode, trans_num, ch_num, pix_num, row_num)` returning `LEN_W` bits;
  - constant `MODE_UPDATE = 2'b10`.
- One sub-module: `rd_req_chan`, a single-channel request holder (valid set on issue, cleared on accept, addr/len registers). Instantiated twice.

## Test plan
- Non-update, `trans_num`=63, `tile_num`=0, readies always 1:
  - → one request per channel with `len`=64, `addr`=base;
  - `pb_start` 2 cycles after accept;
  - `sched_done` 2 cycles after `pb_done`.
- Update, `ch`=3, `pix`=7, `row`=1, `tile_num`=2, `stride1`=0x400, `stride2`=0x800, `base1`=0x1000 → `len`=64 on both channels; `rd1` addrs 0x1000/0x1400/0x1800; 3 `pb_start` pulses.
- `rd1_req_ready` delayed 5 cycles, `rd2` immediate → `rd2` valid drops after 1 cycle, `pb_start` only after `rd1` accept.
- `pb_done` held high throughout → each tile ends on the 2nd WAIT cycle, never during START.
- `base1`=0xFFFF_FC00, `stride1`=0x400, `tile_num`=1 → second `rd1` addr=0x0000_0000.
- `rst` asserted in WAIT → next cycle IDLE, `cmd_ready`=1, no `sched_done`; a new command runs normally.

Source files
------------

// File: rtl/pbuf_load_sched_pkg.sv
// Shared definitions for the parameter-buffer load sequencer: state encoding,
// update-mode constant and the per-tile DDR request length helper.
package GLOBAL_PARAM;

    localparam int unsigned PBUF_LEN_W = 11;
    localparam logic [1:0]  MODE_UPDATE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_WAIT,
        S_NEXT,
        S_FIN
    } pbuf_sched_state_t;

    // Update tiles fetch ch*pix*row words (at most 16*16*4 = 1024), others trans_num+1.
    function automatic logic [PBUF_LEN_W-1:0] pbuf_req_len(
        input logic [3:0] mode,
        input logic [7:0] trans_num,
        input logic [3:0] ch_num,
        input logic [3:0] pix_num,
        input logic [1:0] row_num
    );
        if (mode[2:1] == MODE_UPDATE)
            return (PBUF_LEN_W'(ch_num)  + PBUF_LEN_W'(1)) *
                   (PBUF_LEN_W'(pix_num) + PBUF_LEN_W'(1)) *
                   (PBUF_LEN_W'(row_num) + PBUF_LEN_W'(1));
        else
            return PBUF_LEN_W'(trans_num) + PBUF_LEN_W'(1);
    endfunction

endpackage

// File: rtl/pbuf_load_sched_rd_req_chan.sv
// Single DDR read-request holder: valid is set on issue and cleared on accept;
// address and length are registered at issue and held while valid.
module rd_req_chan #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [LEN_W-1:0]  issue_len,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  len
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            len   <= '0;
        end else if (issue) begin
            valid <= 1'b1;
            addr  <= issue_addr;
            len   <= issue_len;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pbuf_load_sched.sv
// Parameter-buffer load sequencer: splits a layer load into tiles, issues two DDR
// reads per tile and runs ddr2pbuf once per tile. Optional PBUF_SCHED_PERF_EN adds perf counters.
module pbuf_load_sched
    import GLOBAL_PARAM::*;
#(
    parameter int unsigned PE_NUM     = 32,
    parameter int unsigned DDR_ADDR_W = 32,
    parameter int unsigned LEN_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_mode,
    input  logic [7:0]            cmd_trans_num,
    input  logic [3:0]            cmd_ch_num,
    input  logic [3:0]            cmd_pix_num,
    input  logic [1:0]            cmd_row_num,
    input  logic                  cmd_depool,
    input  logic [PE_NUM-1:0]     cmd_mask,
    input  logic [7:0]            cmd_tile_num,
    input  logic [DDR_ADDR_W-1:0] cmd_ddr1_base,
    input  logic [DDR_ADDR_W-1:0] cmd_ddr2_base,
    input  logic [DDR_ADDR_W-1:0] cmd_ddr1_stride,
    input  logic [DDR_ADDR_W-1:0] cmd_ddr2_stride,
    output logic                  rd1_req_valid,
    input  logic                  rd1_req_ready,
    output logic [DDR_ADDR_W-1:0] rd1_req_addr,
    output logic [LEN_W-1:0]      rd1_req_len,
    output logic                  rd2_req_valid,
    input  logic                  rd2_req_ready,
    output logic [DDR_ADDR_W-1:0] rd2_req_addr,
    output logic [LEN_W-1:0]      rd2_req_len,
    output logic                  pb_start,
    input  logic                  pb_done,
    output logic [3:0]            pb_conf_mode,
    output logic [7:0]            pb_conf_trans_num,
    output logic [3:0]            pb_conf_ch_num,
    output logic [3:0]            pb_conf_pix_num,
    output logic [1:0]            pb_conf_row_num,
    output logic                  pb_conf_depool,
    output logic [PE_NUM-1:0]     pb_conf_mask,
`ifdef PBUF_SCHED_PERF_EN
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stall,
`endif
    output logic                  busy,
    output logic                  sched_done
);

    pbuf_sched_state_t state, state_nxt;

    logic                  accept;
    logic                  req_done;
    logic                  done_qual;
    logic                  first_wait;
    logic                  last_tile;
    logic                  issue;
    logic [7:0]            tile_num_q;
    logic [7:0]            tile_cnt;
    logic [DDR_ADDR_W-1:0] stride1_q;
    logic [DDR_ADDR_W-1:0] stride2_q;
    logic [DDR_ADDR_W-1:0] issue_addr1;
    logic [DDR_ADDR_W-1:0] issue_addr2;
    logic [LEN_W-1:0]      issue_len;
    logic [LEN_W-1:0]      cmd_len;

    assign accept    = cmd_valid && cmd_ready;
    assign req_done  = (!rd1_req_valid || rd1_req_ready) && (!rd2_req_valid || rd2_req_ready);
    // The datapath's done level from the previous tile is stale for START and the first WAIT cycle.
    assign done_qual = (state == S_WAIT) && !first_wait && pb_done;
    assign last_tile = (tile_cnt == tile_num_q);
    assign issue     = accept || ((state == S_NEXT) && !last_tile);
    assign cmd_len   = LEN_W'(pbuf_req_len(cmd_mode, cmd_trans_num, cmd_ch_num,
                                           cmd_pix_num, cmd_row_num));

    // Each channel's current address register doubles as the tile address base.
    assign issue_addr1 = accept ? cmd_ddr1_base : rd1_req_addr + stride1_q;
    assign issue_addr2 = accept ? cmd_ddr2_base : rd2_req_addr + stride2_q;
    assign issue_len   = accept ? cmd_len : rd1_req_len;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_REQ;
            S_REQ:   if (req_done) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (done_qual) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = last_tile ? S_FIN : S_REQ;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            cmd_ready         <= 1'b1;
            busy              <= 1'b0;
            pb_start          <= 1'b0;
            sched_done        <= 1'b0;
            first_wait        <= 1'b0;
            tile_cnt          <= '0;
            tile_num_q        <= '0;
            stride1_q         <= '0;
            stride2_q         <= '0;
            pb_conf_mode      <= '0;
            pb_conf_trans_num <= '0;
            pb_conf_ch_num    <= '0;
            pb_conf_pix_num   <= '0;
            pb_conf_row_num   <= '0;
            pb_conf_depool    <= 1'b0;
            pb_conf_mask      <= '0;
        end else begin
            state      <= state_nxt;
            cmd_ready  <= (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            pb_start   <= (state_nxt == S_START);
            sched_done <= (state_nxt == S_FIN);
            first_wait <= (state == S_START);
            if (accept) begin
                tile_cnt          <= '0;
                tile_num_q        <= cmd_tile_num;
                stride1_q         <= cmd_ddr1_stride;
                stride2_q         <= cmd_ddr2_stride;
                pb_conf_mode      <= cmd_mode;
                pb_conf_trans_num <= cmd_trans_num;
                pb_conf_ch_num    <= cmd_ch_num;
                pb_conf_pix_num   <= cmd_pix_num;
                pb_conf_row_num   <= cmd_row_num;
                pb_conf_depool    <= cmd_depool;
                pb_conf_mask      <= cmd_mask;
            end else if (state == S_NEXT) begin
                tile_cnt <= tile_cnt + 8'd1;
            end
        end
    end

    rd_req_chan #(
        .ADDR_W(DDR_ADDR_W),
        .LEN_W (LEN_W)
    ) u_rd1 (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_addr(issue_addr1),
        .issue_len (issue_len),
        .ready     (rd1_req_ready),
        .valid     (rd1_req_valid),
        .addr      (rd1_req_addr),
        .len       (rd1_req_len)
    );

    rd_req_chan #(
        .ADDR_W(DDR_ADDR_W),
        .LEN_W (LEN_W)
    ) u_rd2 (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_addr(issue_addr2),
        .issue_len (issue_len),
        .ready     (rd2_req_ready),
        .valid     (rd2_req_valid),
        .addr      (rd2_req_addr),
        .len       (rd2_req_len)
    );

`ifdef PBUF_SCHED_PERF_EN
    logic [31:0] busy_cycles;
    logic        stall;

    assign stall = (state == S_REQ) &&
                   ((rd1_req_valid && !rd1_req_ready) || (rd2_req_valid && !rd2_req_ready));

    // The FIN cycle itself is busy, so it is added when publishing the total.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            busy_cycles <= '0;
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (busy_cycles != '1))
                busy_cycles <= busy_cycles + 32'd1;
            if (state == S_FIN)
                perf_cycles <= (busy_cycles == '1) ? busy_cycles : busy_cycles + 32'd1;
            if (stall && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pbuf_load_sched.sv
// Scoreboard bench for pbuf_load_sched: stimulus pushes expected requests/configs,
// a negedge monitor pops and compares them and checks handshake timing.
`timescale 1ns/1ps
module tb_pbuf_load_sched;

    typedef struct packed {
        logic [31:0] addr;
        logic [10:0] len;
    } req_t;

    typedef struct packed {
        logic [3:0]  mode;
        logic [7:0]  trans;
        logic [3:0]  ch;
        logic [3:0]  pix;
        logic [1:0]  row;
        logic        depool;
        logic [31:0] mask;
    } conf_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_mode = '0;
    logic [7:0]  cmd_trans_num = '0;
    logic [3:0]  cmd_ch_num = '0;
    logic [3:0]  cmd_pix_num = '0;
    logic [1:0]  cmd_row_num = '0;
    logic        cmd_depool = 1'b0;
    logic [31:0] cmd_mask = '0;
    logic [7:0]  cmd_tile_num = '0;
    logic [31:0] cmd_ddr1_base = '0, cmd_ddr2_base = '0;
    logic [31:0] cmd_ddr1_stride = '0, cmd_ddr2_stride = '0;
    logic        rd1_req_valid, rd2_req_valid;
    logic        rd1_req_ready = 1'b1, rd2_req_ready = 1'b1;
    logic [31:0] rd1_req_addr, rd2_req_addr;
    logic [10:0] rd1_req_len, rd2_req_len;
    logic        pb_start;
    logic        pb_done = 1'b0;
    logic [3:0]  pb_conf_mode;
    logic [7:0]  pb_conf_trans_num;
    logic [3:0]  pb_conf_ch_num;
    logic [3:0]  pb_conf_pix_num;
    logic [1:0]  pb_conf_row_num;
    logic        pb_conf_depool;
    logic [31:0] pb_conf_mask;
    logic        busy, sched_done;
`ifdef PBUF_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    pbuf_load_sched #(
        .PE_NUM    (32),
        .DDR_ADDR_W(32),
        .LEN_W     (11)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_mode         (cmd_mode),
        .cmd_trans_num    (cmd_trans_num),
        .cmd_ch_num       (cmd_ch_num),
        .cmd_pix_num      (cmd_pix_num),
        .cmd_row_num      (cmd_row_num),
        .cmd_depool       (cmd_depool),
        .cmd_mask         (cmd_mask),
        .cmd_tile_num     (cmd_tile_num),
        .cmd_ddr1_base    (cmd_ddr1_base),
        .cmd_ddr2_base    (cmd_ddr2_base),
        .cmd_ddr1_stride  (cmd_ddr1_stride),
        .cmd_ddr2_stride  (cmd_ddr2_stride),
        .rd1_req_valid    (rd1_req_valid),
        .rd1_req_ready    (rd1_req_ready),
        .rd1_req_addr     (rd1_req_addr),
        .rd1_req_len      (rd1_req_len),
        .rd2_req_valid    (rd2_req_valid),
        .rd2_req_ready    (rd2_req_ready),
        .rd2_req_addr     (rd2_req_addr),
        .rd2_req_len      (rd2_req_len),
        .pb_start         (pb_start),
        .pb_done          (pb_done),
        .pb_conf_mode     (pb_conf_mode),
        .pb_conf_trans_num(pb_conf_trans_num),
        .pb_conf_ch_num   (pb_conf_ch_num),
        .pb_conf_pix_num  (pb_conf_pix_num),
        .pb_conf_row_num  (pb_conf_row_num),
        .pb_conf_depool   (pb_conf_depool),
        .pb_conf_mask     (pb_conf_mask),
`ifdef PBUF_SCHED_PERF_EN
        .perf_cycles      (perf_cycles),
        .perf_stall       (perf_stall),
`endif
        .busy             (busy),
        .sched_done       (sched_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    req_t  q1[$];
    req_t  q2[$];
    conf_t qc[$];
    int    qd[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DDR ready and datapath models
    int dly1 = 0, dly2 = 0, wc1 = 0, wc2 = 0;
    int dp_lat = 3, dp_cnt = 0;
    bit dp_hold = 0, dp_mute = 0;
    int exp_rise = -1, exp_fin = -1;

    always @(posedge clk) begin
        #1;
        if (rd1_req_valid) wc1++; else wc1 = 0;
        if (rd2_req_valid) wc2++; else wc2 = 0;
        rd1_req_ready = (dly1 == 0) || (wc1 > dly1);
        rd2_req_ready = (dly2 == 0) || (wc2 > dly2);
        if (dp_hold) begin
            pb_done = 1'b1;
        end else begin
            pb_done = 1'b0;
            if (rst || dp_mute) begin
                dp_cnt = 0;
            end else if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    pb_done  = 1'b1;
                    exp_rise = cyc + 2;
                    exp_fin  = cyc + 2;
                end
            end else if (pb_start) begin
                dp_cnt = dp_lat;
            end
        end
    end

    // Monitor / scoreboard
    logic p_v1 = 0, p_v2 = 0, p_hs1 = 0, p_hs2 = 0, p_start = 0, p_sdone = 0;
    req_t p_r1, p_r2;
    int   acc1 = 0, acc2 = 0;

    always @(negedge clk) begin
        if (rst) begin
            p_v1 = 0; p_v2 = 0; p_hs1 = 0; p_hs2 = 0; p_start = 0; p_sdone = 0;
        end else begin
            if (cmd_valid && cmd_ready) exp_rise = cyc + 1;

            if (p_hs1) chk("rd1_drop", rd1_req_valid, 0);
            if (rd1_req_valid && !p_v1) chk("rd1_rise_cycle", cyc, exp_rise);
            if (rd1_req_valid && p_v1 && !p_hs1) chk("rd1_stable", {rd1_req_addr, rd1_req_len}, p_r1);
            if (rd1_req_valid && rd1_req_ready) begin
                chk("rd1_expected", q1.size() != 0, 1);
                if (q1.size() != 0) chk("rd1_addr_len", {rd1_req_addr, rd1_req_len}, q1.pop_front());
                acc1 = cyc;
            end
            p_v1  = rd1_req_valid;
            p_hs1 = rd1_req_valid && rd1_req_ready;
            p_r1  = {rd1_req_addr, rd1_req_len};

            if (p_hs2) chk("rd2_drop", rd2_req_valid, 0);
            if (rd2_req_valid && !p_v2) chk("rd2_rise_cycle", cyc, exp_rise);
            if (rd2_req_valid && p_v2 && !p_hs2) chk("rd2_stable", {rd2_req_addr, rd2_req_len}, p_r2);
            if (rd2_req_valid && rd2_req_ready) begin
                chk("rd2_expected", q2.size() != 0, 1);
                if (q2.size() != 0) chk("rd2_addr_len", {rd2_req_addr, rd2_req_len}, q2.pop_front());
                acc2 = cyc;
            end
            p_v2  = rd2_req_valid;
            p_hs2 = rd2_req_valid && rd2_req_ready;
            p_r2  = {rd2_req_addr, rd2_req_len};

            if (pb_start) begin
                chk("start_width", p_start, 0);
                chk("start_cycle", cyc, ((acc1 > acc2) ? acc1 : acc2) + 1);
                chk("conf_expected", qc.size() != 0, 1);
                if (qc.size() != 0)
                    chk("pb_conf", {pb_conf_mode, pb_conf_trans_num, pb_conf_ch_num, pb_conf_pix_num,
                                    pb_conf_row_num, pb_conf_depool, pb_conf_mask}, qc.pop_front());
                if (dp_hold) begin
                    exp_rise = cyc + 4;
                    exp_fin  = cyc + 4;
                end
            end
            p_start = pb_start;

            if (p_sdone) chk("ready_after_done", cmd_ready, 1);
            if (sched_done) begin
                chk("done_cycle", cyc, exp_fin);
                chk("done_expected", qd.size() != 0, 1);
                if (qd.size() != 0) void'(qd.pop_front());
            end
            p_sdone = sched_done;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        @(posedge clk); #1;
        while (!(cmd_ready && !busy) && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n < 4000, 1);
    endtask

    task automatic send_cmd(input logic [3:0] mode, input logic [7:0] trans,
                            input logic [3:0] ch, input logic [3:0] pix, input logic [1:0] row,
                            input logic depool, input logic [31:0] mask, input logic [7:0] tiles,
                            input logic [31:0] b1, input logic [31:0] s1,
                            input logic [31:0] b2, input logic [31:0] s2,
                            input logic [10:0] len, input bit expect_done);
        logic [31:0] a1, a2;
        a1 = b1;
        a2 = b2;
        for (int t = 0; t <= int'(tiles); t++) begin
            q1.push_back({a1, len});
            q2.push_back({a2, len});
            qc.push_back({mode, trans, ch, pix, row, depool, mask});
            a1 = a1 + s1;
            a2 = a2 + s2;
        end
        if (expect_done) qd.push_back(1);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_mode = mode; cmd_trans_num = trans; cmd_ch_num = ch; cmd_pix_num = pix;
        cmd_row_num = row; cmd_depool = depool; cmd_mask = mask; cmd_tile_num = tiles;
        cmd_ddr1_base = b1; cmd_ddr1_stride = s1; cmd_ddr2_base = b2; cmd_ddr2_stride = s2;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_mode = 4'($urandom); cmd_trans_num = 8'($urandom); cmd_ch_num = 4'($urandom);
        cmd_pix_num = 4'($urandom); cmd_row_num = 2'($urandom); cmd_mask = $urandom;
        cmd_tile_num = 8'($urandom); cmd_ddr1_base = $urandom; cmd_ddr1_stride = $urandom;
        cmd_ddr2_base = $urandom; cmd_ddr2_stride = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sched_done", sched_done, 0);
        chk("rst_pb_start", pb_start, 0);
        chk("rst_rd_valid", {rd1_req_valid, rd2_req_valid}, 0);
        chk("rst_rd_addr_len", {rd1_req_addr, rd1_req_len, rd2_req_len}, 0);
        chk("rst_rd2_addr", rd2_req_addr, 0);
        chk("rst_conf", {pb_conf_mode, pb_conf_trans_num, pb_conf_ch_num, pb_conf_pix_num,
                         pb_conf_row_num, pb_conf_depool}, 0);
        chk("rst_conf_mask", pb_conf_mask, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single non-update tile, len 64
        send_cmd(4'h0, 8'd63, 4'd5, 4'd2, 2'd0, 1'b0, 32'hA5A5_0001, 8'd0,
                 32'h0000_0100, 32'h40, 32'h0000_2000, 32'h80, 11'd64, 1);
        wait_idle("idle_t1");

        // update mode, 3 tiles, len 4*8*2 = 64
        send_cmd(4'b0100, 8'h11, 4'd3, 4'd7, 2'd1, 1'b1, 32'hFFFF_0000, 8'd2,
                 32'h0000_1000, 32'h400, 32'h0000_3000, 32'h800, 11'd64, 1);
        wait_idle("idle_t2");

        // channel 1 accepts late
        dly1 = 5;
        send_cmd(4'h0, 8'd15, 4'd0, 4'd0, 2'd0, 1'b0, 32'h0000_00FF, 8'd1,
                 32'h0000_5000, 32'h100, 32'h0000_6000, 32'h100, 11'd16, 1);
        wait_idle("idle_t3");
        dly1 = 0;

        // done level held high throughout
        dp_hold = 1;
        send_cmd(4'b0010, 8'd255, 4'd1, 4'd1, 2'd1, 1'b0, 32'h1234_5678, 8'd1,
                 32'h0000_7000, 32'h200, 32'h0000_8000, 32'h200, 11'd256, 1);
        wait_idle("idle_t4");
        dp_hold = 0;

        // address wrap on both channels
        send_cmd(4'h0, 8'd7, 4'd0, 4'd0, 2'd0, 1'b1, 32'h8000_0000, 8'd1,
                 32'hFFFF_FC00, 32'h400, 32'hFFFF_FFF0, 32'h20, 11'd8, 1);
        wait_idle("idle_t5");

        // largest update length, ignored mode bits set
        send_cmd(4'b1101, 8'd3, 4'd15, 4'd15, 2'd3, 1'b0, 32'h0F0F_0F0F, 8'd0,
                 32'h0001_0000, 32'h0, 32'h0002_0000, 32'h0, 11'd1024, 1);
        wait_idle("idle_t6");

        // mode[2:1]=11 is not update mode
        send_cmd(4'b0110, 8'd9, 4'd3, 4'd7, 2'd1, 1'b1, 32'h0000_0001, 8'd0,
                 32'h0003_0000, 32'h0, 32'h0004_0000, 32'h0, 11'd10, 1);
        wait_idle("idle_t7");

        // reset while waiting for the datapath
        dp_mute = 1;
        send_cmd(4'h0, 8'd31, 4'd0, 4'd0, 2'd0, 1'b0, 32'h0000_FFFF, 8'd0,
                 32'h0005_0000, 32'h0, 32'h0006_0000, 32'h0, 11'd32, 0);
        n = 0;
        while (!pb_start && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_test_start_seen", n < 50, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("wait_rst_cmd_ready", cmd_ready, 1);
        chk("wait_rst_busy", busy, 0);
        chk("wait_rst_valids", {rd1_req_valid, rd2_req_valid, pb_start, sched_done}, 0);
        dp_mute = 0;
        repeat (6) @(posedge clk);

        // normal command after reset, channel 2 late
        dly2 = 2;
        send_cmd(4'b0101, 8'd0, 4'd1, 4'd1, 2'd0, 1'b1, 32'hDEAD_BEEF, 8'd3,
                 32'h0007_0000, 32'h10, 32'h0008_0000, 32'h20, 11'd4, 1);
        wait_idle("idle_t9");
        dly2 = 0;

        // 256 tiles
        dp_lat = 2;
        send_cmd(4'h0, 8'd0, 4'd0, 4'd0, 2'd0, 1'b0, 32'h0000_0003, 8'd255,
                 32'h0009_0000, 32'h4, 32'h000A_0000, 32'h8, 11'd1, 1);
        wait_idle("idle_t10");

        repeat (5) @(posedge clk);
        chk("q_rd1_empty", q1.size(), 0);
        chk("q_rd2_empty", q2.size(), 0);
        chk("q_conf_empty", qc.size(), 0);
        chk("q_done_empty", qd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
